// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and helpers for the FIFO-bank round-robin drain stage.
// Holds the drain FSM state encoding and the index-width helper.
package fifo_rr_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    HOLD = 2'd2
  } drain_state_t;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_if.sv
// Bank-side read/empty/data signals plus the valid/ready output stream.
// Signal prefixes are from the drain stage's point of view (slave modport).
interface fifo_rr_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_FIFOS  = 4
);
  import fifo_rr_drain_pkg::*;

  localparam int ID_WIDTH = clog2_min1(NUM_FIFOS);

  logic [NUM_FIFOS-1:0]            i_fifo_empty;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] i_fifo_dout;
  logic [NUM_FIFOS-1:0]            o_fifo_rd_en;
  logic [NUM_FIFOS-1:0]            i_src_en;
  logic                            o_out_valid;
  logic                            i_out_ready;
  logic [DATA_WIDTH-1:0]           o_out_data;
  logic [ID_WIDTH-1:0]             o_out_id;

  modport slave (
    input  i_fifo_empty, i_fifo_dout, i_src_en, i_out_ready,
    output o_fifo_rd_en, o_out_valid, o_out_data, o_out_id
  );

  modport master (
    output i_fifo_empty, i_fifo_dout, i_src_en, i_out_ready,
    input  o_fifo_rd_en, o_out_valid, o_out_data, o_out_id
  );

endinterface

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr+1,
// wrapping around, found on a doubled request vector shifted down by ptr+1.
module rr_pick #(
  parameter int NUM_FIFOS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic [NUM_FIFOS-1:0] i_req,
  input  logic [ID_WIDTH-1:0]  i_ptr,
  output logic                 o_gnt_valid,
  output logic [ID_WIDTH-1:0]  o_gnt_idx
);

  logic [2*NUM_FIFOS-1:0] w_req2;
  logic [2*NUM_FIFOS-1:0] w_shift;
  int                     w_start;

  always_comb begin
    w_req2      = {i_req, i_req};
    w_start     = (int'(i_ptr) >= NUM_FIFOS - 1) ? 0 : int'(i_ptr) + 1;
    w_shift     = w_req2 >> w_start;
    o_gnt_valid = |i_req;
    o_gnt_idx   = '0;
    // Descending scan so the lowest rotated position wins
    for (int k = 2*NUM_FIFOS - 1; k >= 0; k--) begin
      if (w_shift[k]) o_gnt_idx = ID_WIDTH'((w_start + k) % NUM_FIFOS);
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Drain stage for the multi-FIFO bank: round-robin reads of non-empty, enabled
// FIFOs, presented as one valid/ready stream tagged with the source index.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_FIFOS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_rr_drain_if.slave bus
);

  localparam int ID_WIDTH = clog2_min1(NUM_FIFOS);

  drain_state_t          r_state;
  drain_state_t          w_next;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_sel;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_valid;

  logic [NUM_FIFOS-1:0]  w_elig;
  logic [NUM_FIFOS-1:0]  w_rd_en;
  logic                  w_gnt_valid;
  logic [ID_WIDTH-1:0]   w_gnt_idx;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_slice;

  assign w_elig = bus.i_src_en & ~bus.i_fifo_empty;

  rr_pick #(
    .NUM_FIFOS (NUM_FIFOS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pick (
    .i_req       (w_elig),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_issue = 1'b1;
          w_next  = CAP;
        end
      end
      CAP: w_next = HOLD;
      HOLD: begin
        if (r_valid && bus.i_out_ready) begin
          w_issue = w_gnt_valid;
          w_next  = w_gnt_valid ? CAP : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Read strobe is gated by rst_n so the bank never sees a read during reset
  always_comb begin
    w_rd_en = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      w_rd_en[i] = w_issue && rst_n && (w_gnt_idx == ID_WIDTH'(i));
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (r_sel == ID_WIDTH'(i)) w_slice = bus.i_fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= ID_WIDTH'(NUM_FIFOS - 1);
      r_sel   <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_ptr <= w_gnt_idx;
        r_sel <= w_gnt_idx;
      end
      if (r_state == CAP) begin
        r_data  <= w_slice;
        r_id    <= r_sel;
        r_valid <= 1'b1;
      end else if (r_state == HOLD && r_valid && bus.i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_fifo_rd_en = w_rd_en;
  assign bus.o_out_valid  = r_valid;
  assign bus.o_out_data   = r_data;
  assign bus.o_out_id     = r_id;

endmodule
